// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared state encoding, ALU op codes and counter sizing for alu_issue_ctrl
package alu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/alu_timeout_cnt.sv
// rtl/alu_timeout_cnt.sv - WAIT-cycle counter flagging the last permitted cycle
module alu_timeout_cnt
    import alu_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;

    // cnt_q holds completed WAIT cycles, so the current cycle is cnt_q+1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded ALU op, waits for the result with timeout, hands it to writeback
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int BUS_WIDTH      = 32,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [BUS_WIDTH-1:0]      req_rs_data,
    input  logic [BUS_WIDTH-1:0]      req_imme_rs,
    input  logic [OPCODE_WIDTH-1:0]   req_op_code,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd_addr,
    output logic [BUS_WIDTH-1:0]      rs_data,
    output logic [BUS_WIDTH-1:0]      imme_rs,
    output logic [OPCODE_WIDTH-1:0]   op_code,
    input  logic [BUS_WIDTH-1:0]      alu_data_out,
    input  logic                      alu_data_valid,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
    output logic [BUS_WIDTH-1:0]      wb_data,
    output logic                      busy,
    output logic                      err_timeout
);

    state_e                    state_q, state_d;
    logic [BUS_WIDTH-1:0]      rs_data_q, rs_data_d;
    logic [BUS_WIDTH-1:0]      imme_rs_q, imme_rs_d;
    logic [OPCODE_WIDTH-1:0]   op_code_q, op_code_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_addr_q, wb_rd_addr_d;
    logic [BUS_WIDTH-1:0]      wb_data_q, wb_data_d;
    logic                      err_q, err_d;
    logic                      cnt_clear, cnt_en, cnt_expired;

    alu_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (cnt_clear),
        .en_i     (cnt_en),
        .expired_o(cnt_expired)
    );

    always_comb begin
        state_d      = state_q;
        rs_data_d    = rs_data_q;
        imme_rs_d    = imme_rs_q;
        op_code_d    = op_code_q;
        rd_addr_d    = rd_addr_q;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_data_d    = wb_data_q;
        err_d        = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    rs_data_d = req_rs_data;
                    imme_rs_d = req_imme_rs;
                    op_code_d = req_op_code;
                    rd_addr_d = req_rd_addr;
                    cnt_clear = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (alu_data_valid) begin
                    wb_data_d    = alu_data_out;
                    wb_rd_addr_d = rd_addr_q;
                    // x0 writes are architecturally dropped, so skip the writeback handshake
                    state_d      = (rd_addr_q != '0) ? ST_WB : ST_IDLE;
                end else if (cnt_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rs_data_q    <= '0;
            imme_rs_q    <= '0;
            op_code_q    <= '0;
            rd_addr_q    <= '0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rs_data_q    <= rs_data_d;
            imme_rs_q    <= imme_rs_d;
            op_code_q    <= op_code_d;
            rd_addr_q    <= rd_addr_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = !req_ready;
    assign wb_valid    = (state_q == ST_WB);
    assign rs_data     = rs_data_q;
    assign imme_rs     = imme_rs_q;
    assign op_code     = op_code_q;
    assign wb_rd_addr  = wb_rd_addr_q;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - table-driven directed bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs_data;
    logic [31:0] req_imme_rs;
    logic [3:0]  req_op_code;
    logic [4:0]  req_rd_addr;
    logic [31:0] rs_data;
    logic [31:0] imme_rs;
    logic [3:0]  op_code;
    logic [31:0] alu_data_out;
    logic        alu_data_valid;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        busy;
    logic        err_timeout;

    alu_issue_ctrl #(
        .BUS_WIDTH(32), .OPCODE_WIDTH(4), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs_data(req_rs_data), .req_imme_rs(req_imme_rs),
        .req_op_code(req_op_code), .req_rd_addr(req_rd_addr),
        .rs_data(rs_data), .imme_rs(imme_rs), .op_code(op_code),
        .alu_data_out(alu_data_out), .alu_data_valid(alu_data_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rs;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [4:0]  rd;
        int          vk;
        logic [31:0] want;
        int          stall;
        bit          stray;
    } vec_t;

    vec_t tbl[10];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;
    int   err_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (wb_valid && wb_ready) hs_cnt++;
            if (err_timeout) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $signed(a) >>> b[4:0];
            OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            OP_SLTU: return {31'd0, a < b};
            default: return 32'h0;
        endcase
    endfunction

    task automatic accept(input vec_t v, input bit stray);
        req_valid      = 1'b1;
        req_rs_data    = v.rs;
        req_imme_rs    = v.imm;
        req_op_code    = v.op;
        req_rd_addr    = v.rd;
        alu_data_valid = stray;
        alu_data_out   = 32'h0BAD_0BAD;
        chk("accept_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid      = 1'b0;
        alu_data_valid = 1'b0;
        req_rs_data    = '0;
        req_imme_rs    = '0;
        req_op_code    = '0;
        chk("issue_rs", rs_data, v.rs);
        chk("issue_imm", imme_rs, v.imm);
        chk("issue_op", {28'd0, op_code}, {28'd0, v.op});
    endtask

    task automatic run_op(input vec_t v);
        int  hs0;
        int  er0;
        bit  done;
        hs0 = hs_cnt;
        er0 = err_cnt;
        if (v.stray) begin
            alu_data_valid = 1'b1;
            alu_data_out   = 32'hDEAD_BEEF;
            tick();
            alu_data_valid = 1'b0;
            chk("stray_idle_ready", {31'd0, req_ready}, 32'd1);
        end
        accept(v, v.stray);
        done = 1'b0;
        for (int k = 1; k <= T && !done; k++) begin
            chk("wait_busy", {31'd0, busy}, 32'd1);
            chk("wait_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("wait_no_err", {31'd0, err_timeout}, 32'd0);
            if (k == v.vk) begin
                alu_data_valid = 1'b1;
                alu_data_out   = alu_model(v.op, v.rs, v.imm);
                done = 1'b1;
            end
            tick();
            alu_data_valid = 1'b0;
        end
        if (v.vk == 0) begin
            chk("timeout_err", {31'd0, err_timeout}, 32'd1);
            chk("timeout_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("timeout_ready", {31'd0, req_ready}, 32'd1);
            tick();
            chk("timeout_err_once", {31'd0, err_timeout}, 32'd0);
        end else if (v.rd == 5'd0) begin
            chk("x0_no_wb", {31'd0, wb_valid}, 32'd0);
            chk("x0_ready", {31'd0, req_ready}, 32'd1);
            chk("x0_wb_data", wb_data, v.want);
            chk("x0_no_err", {31'd0, err_timeout}, 32'd0);
        end else begin
            wb_ready = 1'b0;
            for (int s = 0; s < v.stall; s++) begin
                chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("stall_wb_data", wb_data, v.want);
                chk("stall_wb_rd", {27'd0, wb_rd_addr}, {27'd0, v.rd});
                chk("stall_not_ready", {31'd0, req_ready}, 32'd0);
                alu_data_valid = v.stray;
                alu_data_out   = 32'hFACE_FACE;
                tick();
                alu_data_valid = 1'b0;
            end
            wb_ready = 1'b1;
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wb_data", wb_data, v.want);
            chk("wb_rd", {27'd0, wb_rd_addr}, {27'd0, v.rd});
            tick();
            chk("wb_done_valid", {31'd0, wb_valid}, 32'd0);
            chk("wb_done_ready", {31'd0, req_ready}, 32'd1);
        end
        chk("handshakes", hs_cnt - hs0, (v.vk != 0 && v.rd != 5'd0) ? 32'd1 : 32'd0);
        chk("err_pulses", err_cnt - er0, (v.vk == 0) ? 32'd1 : 32'd0);
        chk("operand_hold", rs_data, v.rs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int hs0;
        int er0;
        tbl[0] = '{32'h0000_0005, 32'h0000_0003, OP_ADD,  5'd7,  1,  32'h0000_0008, 0, 1'b0};
        tbl[1] = '{32'h0000_0005, 32'h0000_0003, OP_ADD,  5'd7,  1,  32'h0000_0008, 5, 1'b0};
        tbl[2] = '{32'h0000_000A, 32'h0000_0003, OP_SUB,  5'd1,  3,  32'h0000_0007, 2, 1'b0};
        tbl[3] = '{32'hFF00_FF00, 32'h0FF0_0FF0, OP_XOR,  5'd31, T,  32'hF0F0_F0F0, 0, 1'b0};
        tbl[4] = '{32'h0000_0001, 32'h0000_0002, OP_ADD,  5'd3,  0,  32'h0000_0000, 0, 1'b0};
        tbl[5] = '{32'h0000_F0F0, 32'h0000_FF00, OP_AND,  5'd0,  3,  32'h0000_F000, 0, 1'b0};
        tbl[6] = '{32'h0000_0001, 32'h0000_0004, OP_SLL,  5'd2,  2,  32'h0000_0010, 1, 1'b1};
        tbl[7] = '{32'h8000_0000, 32'h0000_0004, OP_SRA,  5'd9,  1,  32'hF800_0000, 2, 1'b1};
        tbl[8] = '{32'h0000_0001, 32'hFFFF_FFFF, OP_SLTU, 5'd4,  5,  32'h0000_0001, 0, 1'b0};
        tbl[9] = '{32'hFFFF_FFFF, 32'h0000_0001, OP_SLT,  5'd5,  4,  32'h0000_0001, 0, 1'b0};

        rst_n = 1'b0; req_valid = 1'b0; req_rs_data = '0; req_imme_rs = '0;
        req_op_code = '0; req_rd_addr = '0; alu_data_out = '0; alu_data_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_err", {31'd0, err_timeout}, 32'd0);
        chk("rst_rs", rs_data, 32'd0);
        chk("rst_imm", imme_rs, 32'd0);
        chk("rst_op", {28'd0, op_code}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd_addr}, 32'd0);

        for (int i = 0; i < 10; i++) run_op(tbl[i]);

        // reset while waiting at k=4
        hs0 = hs_cnt; er0 = err_cnt;
        accept(tbl[0], 1'b0);
        tick(); tick(); tick();
        chk("mid_wait_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_wait_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_wait_rs", rs_data, 32'd0);
        chk("rst_wait_err", {31'd0, err_timeout}, 32'd0);
        for (int i = 0; i < T + 2; i++) tick();
        chk("rst_wait_no_err", err_cnt - er0, 32'd0);
        chk("rst_wait_no_hs", hs_cnt - hs0, 32'd0);
        run_op(tbl[2]);

        // reset while the result is being held for writeback
        hs0 = hs_cnt;
        accept(tbl[0], 1'b0);
        alu_data_valid = 1'b1;
        alu_data_out   = 32'h0000_0008;
        wb_ready       = 1'b0;
        tick();
        alu_data_valid = 1'b0;
        chk("pre_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_wb_valid_clr", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_data_clr", wb_data, 32'd0);
        chk("rst_wb_rd_clr", {27'd0, wb_rd_addr}, 32'd0);
        chk("rst_wb_ready", {31'd0, req_ready}, 32'd1);
        wb_ready = 1'b1;
        tick();
        chk("rst_wb_no_hs", hs_cnt - hs0, 32'd0);
        run_op(tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU operand/result interface: accepts one decoded ALU request per handshake and drives the registered operands and op_code to the ALU.
- Waits for alu_data_valid with a bounded timeout, captures alu_data_out, and presents the result plus destination register to the writeback stage over a valid/ready handshake.
- Sits between the decode stage and the register-file writeback port.

Parameters:
- BUS_WIDTH, 32, operand/result width.
- OPCODE_WIDTH, 4, ALU op_code width.
- REG_ADDR_WIDTH, 5, destination register address width.
- TIMEOUT_CYCLES, 16, max WAIT cycles for alu_data_valid; legal range >=1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  decode request valid.
- req_ready  out  1  block can accept a request.
- req_rs_data  in  BUS_WIDTH  register source operand.
- req_imme_rs  in  BUS_WIDTH  immediate operand.
- req_op_code  in  OPCODE_WIDTH  ALU operation.
- req_rd_addr  in  REG_ADDR_WIDTH  destination register.
- rs_data  out  BUS_WIDTH  operand to ALU.
- imme_rs  out  BUS_WIDTH  immediate to ALU.
- op_code  out  OPCODE_WIDTH  op_code to ALU.
- alu_data_out  in  BUS_WIDTH  ALU result.
- alu_data_valid  in  1  ALU result valid.
- wb_valid  out  1  writeback data valid.
- wb_ready  in  1  writeback sink ready.
- wb_rd_addr  out  REG_ADDR_WIDTH  writeback destination.
- wb_data  out  BUS_WIDTH  captured ALU result.
- busy  out  1  state != IDLE.
- err_timeout  out  1  one-cycle pulse on ALU timeout.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; rs_data, imme_rs, op_code, wb_data, wb_rd_addr = 0; wb_valid=0; err_timeout=0; timeout counter=0. Reset overrides every transition, including mid-WAIT or mid-WB; any pending result is dropped.
- req_ready = (state==IDLE), combinational from state. busy = !req_ready.
- IDLE:
  - On req_valid && req_ready, register req_rs_data/req_imme_rs/req_op_code onto rs_data/imme_rs/op_code, latch rd_addr, clear counter, go to WAIT.
  - ALU operands are stable from the cycle after acceptance.
- WAIT:
  - alu_data_valid is sampled only in WAIT, and is ignored in IDLE (including the accept cycle) and in WB.
  - The counter increments each WAIT cycle; the first WAIT cycle is k=1.
  - If alu_data_valid=1 in cycle k<=TIMEOUT_CYCLES: capture alu_data_out into wb_data and rd_addr into wb_rd_addr.
    - rd_addr != 0: go to WB.
    - rd_addr == 0: discard (x0 write), go to IDLE.
  - If k==TIMEOUT_CYCLES and alu_data_valid=0: go to IDLE, err_timeout=1 for exactly the next cycle, no writeback.
- WB: wb_valid=1. Hold wb_data and wb_rd_addr stable until wb_valid && wb_ready, then go to IDLE with wb_valid=0 the next cycle. Backpressure is unbounded; no timeout applies in WB.
- Operand outputs hold the last issued values after completion and do not return to 0.
- Minimum latency: accept at cycle 0, alu_data_valid at cycle 1, wb_valid at cycle 2. One request in flight; peak throughput is one op per 3 cycles.
- wb_data is a raw copy of alu_data_out; no width conversion or sign handling.

Decomposition:
- Package alu_issue_pkg:
  - state enum (IDLE, WAIT, WB), 2-bit.
  - ALU op_code localparams shared with the ALU (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU).
  - Timeout counter width function clog2(TIMEOUT_CYCLES+1).
- One sub-module: alu_timeout_cnt (clear, enable, expired flag at count==TIMEOUT_CYCLES). The FSM and datapath registers stay in the top.

Test Plan:
- Reset then idle: rst_n low 2 cycles -> all outputs 0, req_ready=1, busy=0.
- Nominal: req rs=0x0000_0005, imm=0x0000_0003, op=ADD, rd=7; ALU returns valid with 0x8 one cycle later; wb_ready=1 -> wb_valid at cycle 2 with wb_data=0x8, wb_rd_addr=7; req_ready back to 1 at cycle 3.
- Backpressure: same request, wb_ready=0 for 5 cycles -> wb_valid and wb_data=0x8 held 6 cycles; exactly one handshake; req_ready=0 throughout.
- Timeout: TIMEOUT_CYCLES=16, alu_data_valid never asserted -> exactly one err_timeout pulse 17 cycles after accept, no wb_valid; valid at k=16 instead -> captured, no error.
- x0 and stray valid: rd=0 with valid at k=3 -> no wb_valid, IDLE next cycle; alu_data_valid pulsed in IDLE and in the accept cycle -> ignored, capture only on the WAIT-cycle valid.
- Reset mid-op: rst_n low during WAIT k=4, and again during WB -> IDLE, wb_valid=0, no err_timeout, next request processed normally.
